// File: rtl/dmem_ls.sv
// dmem_ls: byte-addressed data memory with sized, extended loads/stores and a one-outstanding valid/ready handshake
module dmem_ls #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 32,
  parameter int INIT_IDX = 15,
  parameter logic [31:0] INIT_VAL = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state;
  logic [31:0] mem [DEPTH] = '{INIT_IDX: INIT_VAL, default: 32'h0};
  logic [AW-1:0] idx;
  logic [1:0] lane;
  logic err;
  logic [31:0] rword, sh, ld, wd;
  logic [3:0] be;
  assign idx = req_addr[AW+1:2];
  assign lane = req_addr[1:0];
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  // upper index bits set means the word index is past DEPTH (DEPTH is a power of two)
  always_comb begin
    err = req_size == 2'b11 || (req_size == 2'b01 && lane[0]) || (req_size == 2'b10 && lane != 2'b00)
          || |req_addr[ADDR_W-1:AW+2];
    rword = mem[idx];
    sh = rword >> {lane, 3'b000};
    ld = req_size == 2'b00 ? {{24{~req_unsigned & sh[7]}}, sh[7:0]} :
         req_size == 2'b01 ? {{16{~req_unsigned & sh[15]}}, sh[15:0]} : rword;
    wd = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
         req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    be = req_size == 2'b00 ? 4'b0001 << lane :
         req_size == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  // memory lives in the reset process so an accept coinciding with reset never writes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        state <= RESP;
        resp_err <= err;
        resp_rdata <= (err || req_we) ? '0 : ld;
        if (req_we && !err)
          for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end else if (resp_ready) state <= IDLE;
endmodule

// File: tb/tb_dmem_ls.sv
// tb_dmem_ls: randomized and directed checks of dmem_ls against a byte-array reference model
module tb_dmem_ls;
  localparam int DEPTH = 64;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_ready = 0, resp_err;
  logic [31:0] resp_rdata;
  int n_chk = 0, n_fail = 0;
  logic exp_busy = 0, exp_err = 0;
  logic [31:0] exp_rdata = 0;
  logic [7:0] mm [DEPTH*4];
  logic [31:0] rd;
  logic e;

  dmem_ls #(.DEPTH(DEPTH), .ADDR_W(32), .INIT_IDX(15), .INIT_VAL(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
    end
  endtask

  // byte-array model: size in bytes, natural alignment, bounds, little-endian assembly
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] r, output logic er);
    int n;
    logic [31:0] v;
    n = size == 2'd0 ? 1 : size == 2'd1 ? 2 : 4;
    er = size == 2'd3 || (addr % n) != 0 || (addr / 4) >= DEPTH;
    r = 0;
    if (!er) begin
      if (we) for (int k = 0; k < n; k++) mm[addr + k] = wdata[8*k +: 8];
      else begin
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(mm[addr + k]) << (8*k));
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        r = v;
      end
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("req_ready", {31'b0, req_ready}, {31'b0, !exp_busy});
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_busy});
    if (exp_busy) begin
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
    end
  end

  // driver runs at posedge+1; garbage on req_* during RESP must be ignored
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] r, output logic er);
    req_valid = 1; req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    model(we, size, uns, addr, wdata, exp_rdata, exp_err);
    exp_busy = 1;
    r = resp_rdata; er = resp_err;
    req_valid = 0;
    repeat (hold) begin
      req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      @(posedge clk); #1;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0; exp_busy = 0; req_valid = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH*4; i++) mm[i] = 0;
    mm[60] = 8'hEF; mm[61] = 8'hBE; mm[62] = 8'hAD; mm[63] = 8'hDE;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, resp_valid}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", {31'b0, resp_err}, 0);
    rst_n = 1;
    @(posedge clk); #1;
    access(0, 2'd2, 0, 32'h3C, 0, 0, rd, e); chk("ld_w_3c", rd, 32'hDEADBEEF); chk("ld_w_3c_err", {31'b0, e}, 0);
    access(0, 2'd0, 0, 32'h3C, 0, 1, rd, e); chk("ld_b_s_3c", rd, 32'hFFFFFFEF);
    access(0, 2'd0, 1, 32'h3F, 0, 0, rd, e); chk("ld_b_u_3f", rd, 32'h000000DE);
    access(0, 2'd1, 0, 32'h3E, 0, 0, rd, e); chk("ld_h_s_3e", rd, 32'hFFFFDEAD);
    access(0, 2'd1, 1, 32'h3C, 0, 0, rd, e); chk("ld_h_u_3c", rd, 32'h0000BEEF);
    access(1, 2'd0, 0, 32'h3D, 32'h12, 0, rd, e); chk("st_b_rdata", rd, 0);
    access(0, 2'd2, 0, 32'h3C, 0, 0, rd, e); chk("ld_after_stb", rd, 32'hDEAD12EF);
    access(1, 2'd1, 0, 32'h00, 32'hCAFE, 0, rd, e);
    access(0, 2'd2, 0, 32'h00, 0, 0, rd, e); chk("ld_after_sth0", rd, 32'h0000CAFE);
    access(1, 2'd1, 0, 32'h06, 32'hCAFE, 0, rd, e);
    access(0, 2'd2, 0, 32'h04, 0, 0, rd, e); chk("ld_after_sth6", rd, 32'hCAFE0000);
    access(0, 2'd2, 0, 32'h02, 0, 0, rd, e); chk("misal_w_err", {31'b0, e}, 1); chk("misal_w_rd", rd, 0);
    access(1, 2'd1, 0, 32'h41, 32'hFFFF, 0, rd, e); chk("misal_h_err", {31'b0, e}, 1);
    access(0, 2'd2, 0, 32'h40, 0, 0, rd, e); chk("no_write_40", rd, 0);
    access(0, 2'd2, 0, DEPTH*4, 0, 0, rd, e); chk("range_err", {31'b0, e}, 1);
    access(0, 2'd3, 0, 32'h10, 0, 0, rd, e); chk("size3_err", {31'b0, e}, 1);
    access(0, 2'd2, 0, 32'h3C, 0, 5, rd, e); chk("bp_rdata", rd, 32'hDEAD12EF);
    // reset while a load response is pending; earlier store must survive
    access(1, 2'd2, 0, 32'h10, 32'h55AA55AA, 0, rd, e);
    req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h3C;
    @(posedge clk); #1;
    model(0, 2'd2, 0, 32'h3C, 0, exp_rdata, exp_err);
    exp_busy = 1; req_valid = 0;
    @(negedge clk); #1;
    rst_n = 0; exp_busy = 0;
    #1;
    chk("rst_drop_valid", {31'b0, resp_valid}, 0);
    chk("rst_drop_rdata", resp_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1;
    access(0, 2'd2, 0, 32'h10, 0, 0, rd, e); chk("st_survives_rst", rd, 32'h55AA55AA);
    // accept coinciding with reset must not write
    rst_n = 0; req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 0; rst_n = 1;
    @(posedge clk); #1;
    access(0, 2'd2, 0, 32'h20, 0, 0, rd, e); chk("rst_accept_nowrite", rd, 0);
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      a = $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, DEPTH*4 + 7));
      access(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3), rd, e);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
